nand_dq_calib_ctrl: RTL and testbench
=====================================

NAND_DQ_CALIB_CTRL -- requirements
Module: nand_dq_calib_ctrl

Interface
REQ-001 Parameter DQ_WIDTH, default 8: number of DQ IOBs sequenced.
REQ-002 Parameter TAP_MAX, default 31: highest IDELAY tap index; tap counters are 5 bits wide.
REQ-003 Parameter SETTLE_CYC, default 8: wait cycles after any tap change before sampling.
REQ-004 Parameter SAMPLE_CNT, default 4: consecutive matching samples required for a tap to pass.
REQ-005 Parameter PAT_RISE, default 8'hA5: expected per-bit rise pattern; bit b is expected on DQ b.
REQ-006 Parameter PAT_FALL, default 8'h5A: expected per-bit fall pattern.
REQ-007 clk90  in  1  sole clock; all logic rising-edge.
REQ-008 rst90  in  1  synchronous, active-high reset.
REQ-009 calib_start  in  1  single-cycle request to begin calibration.
REQ-010 rd_data_rise  in  DQ_WIDTH  captured rise data from DQ IOBs.
REQ-011 rd_data_fall  in  DQ_WIDTH  captured fall data from DQ IOBs.
REQ-012 dlyce  out  DQ_WIDTH  per-bit IDELAY tap-change enable, one-cycle pulses.
REQ-013 dlyinc  out  1  tap direction: 1 = increment, 0 = decrement; qualified by dlyce.
REQ-014 dlyrst  out  1  resets all IDELAY taps to 0.
REQ-015 calib_busy  out  1  high from the cycle after an accepted start until DONE or ERR.
REQ-016 calib_done  out  1  high while in DONE.
REQ-017 calib_err  out  1  high while in ERR.
REQ-018 err_bit  out  3  index of the failing bit, valid while calib_err is high.

Function
REQ-019 States: IDLE, RST_TAPS, SETTLE, SAMPLE, EVAL, INC, CENTER, NEXT_BIT, DONE, ERR.
REQ-020 calib_start is accepted only in IDLE, DONE or ERR, and causes a transition to RST_TAPS; it is ignored in every other state.
REQ-021 On acceptance: bit index = 0, tap = 0, all window registers cleared.
REQ-022 RST_TAPS: dlyrst = 1 for exactly one cycle, then SETTLE; dlyrst is never asserted again during a run.
REQ-023 SETTLE: count SETTLE_CYC cycles, then SAMPLE.
REQ-024 SAMPLE: each cycle, compare rd_data_rise[b] with PAT_RISE[b] and rd_data_fall[b] with PAT_FALL[b].
  - On any mismatch, the tap fails immediately and the state goes to EVAL.
  - After SAMPLE_CNT consecutive matches, the tap passes and the state goes to EVAL.
REQ-025 EVAL on pass: if cur_len == 0 then cur_start = tap; cur_len += 1; if cur_len (after increment) > best_len then best_start = cur_start and best_len = cur_len.
REQ-026 EVAL on fail: cur_len = 0.
REQ-027 Ties in window length keep the earlier window (strictly-greater compare only).
REQ-028 After EVAL:
  - if tap < TAP_MAX, go to INC;
  - else if best_len == 0, go to ERR with err_bit = b;
  - else go to CENTER.
REQ-029 INC: dlyce[b] = 1 and dlyinc = 1 for one cycle, tap += 1, then SETTLE.
REQ-030 CENTER: center = best_start + ((best_len - 1) >> 1). Issue (TAP_MAX - center) single-cycle pulses of dlyce[b] with dlyinc = 0, one per cycle, then NEXT_BIT. Zero pulses are issued if center == TAP_MAX.
REQ-031 NEXT_BIT:
  - if b == DQ_WIDTH-1, go to DONE;
  - else b += 1, tap = 0, cur_len = best_len = 0, then SETTLE.
  - Taps of later bits are still 0 from RST_TAPS; no re-reset is needed.
REQ-032 Only dlyce[b] may be asserted during bit b's sweep; all other dlyce bits stay 0.
REQ-033 A window that touches tap 0 or TAP_MAX is valid. A window of all 32 taps gives center 15.
REQ-034 Window arithmetic: cur_len and best_len are 6 bits (maximum value 32); no wrap-around is permitted.
REQ-035 dlyinc is 0 whenever dlyce is all-zero.

Reset
REQ-036 While rst90 is sampled high, the next state is IDLE.
REQ-037 Reset values: dlyce = 0, dlyinc = 0, dlyrst = 0, calib_busy = 0, calib_done = 0, calib_err = 0, err_bit = 0; all counters and window registers = 0.
REQ-038 Reset mid-run abandons the calibration; taps are left as-is until the next accepted calib_start.

Verification
REQ-039 Model all 8 bits passing at taps 10..20, rest failing; pulse start -> per bit: 31 increments then 16 decrements (center 15); calib_done = 1, calib_err = 0.
REQ-040 Bit 3 windows 2..5 and 20..23 (equal length) -> bit 3 centers at tap 3 (28 decrements).
REQ-041 Bit 5 never matches -> after bit 5 reaches tap 31: calib_err = 1, err_bit = 5, calib_done = 0, no dlyce[6] or dlyce[7] pulses.
REQ-042 All taps pass on bit 0 -> center 15; single mismatch in sample 3 of tap 12 with a passing window otherwise -> window split at 12.
REQ-043 Assert rst90 during bit 2's SAMPLE -> next cycle all outputs at reset values; calib_start while busy is ignored; calib_start in DONE restarts with one dlyrst pulse.

Source files
------------

// File: rtl/nand_dq_calib_ctrl.sv
// Per-bit IDELAY tap sweep for NAND DQ read capture: finds the widest passing
// tap window on each DQ bit in turn and parks that bit's delay at the window center.
module nand_dq_calib_ctrl #(
    parameter int                  DQ_WIDTH   = 8,
    parameter int                  TAP_MAX    = 31,
    parameter int                  SETTLE_CYC = 8,
    parameter int                  SAMPLE_CNT = 4,
    parameter logic [DQ_WIDTH-1:0] PAT_RISE   = 8'hA5,
    parameter logic [DQ_WIDTH-1:0] PAT_FALL   = 8'h5A
) (
    input  logic                clk90,
    input  logic                rst90,
    input  logic                calib_start,
    input  logic [DQ_WIDTH-1:0] rd_data_rise,
    input  logic [DQ_WIDTH-1:0] rd_data_fall,
    output logic [DQ_WIDTH-1:0] dlyce,
    output logic                dlyinc,
    output logic                dlyrst,
    output logic                calib_busy,
    output logic                calib_done,
    output logic                calib_err,
    output logic [2:0]          err_bit,
    output logic [3:0]          o_dbg_state
);

    localparam logic [4:0] TAP_LAST    = 5'(TAP_MAX);
    localparam logic [5:0] TAP_LAST6   = 6'(TAP_MAX);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CNT - 1);
    localparam logic [2:0] BIT_LAST    = 3'(DQ_WIDTH - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_RST_TAPS, ST_SETTLE, ST_SAMPLE, ST_EVAL,
        ST_INC, ST_CENTER, ST_NEXT_BIT, ST_DONE, ST_ERR
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_bit;
    logic [4:0] r_tap;
    logic [7:0] r_cnt;
    logic       r_pass;
    logic [4:0] r_cur_start, r_best_start;
    logic [5:0] r_cur_len, r_best_len;
    logic [2:0] r_err_bit;

    logic                w_match;
    logic [DQ_WIDTH-1:0] w_bit_sel;
    logic [5:0]          w_cur_len_upd, w_best_len_upd;
    logic [4:0]          w_cur_start_upd, w_best_start_upd;
    logic                w_best_upd;
    logic [5:0]          w_half, w_center, w_pulses;
    logic                w_last_tap;

    assign w_match   = (rd_data_rise[r_bit] == PAT_RISE[r_bit]) &&
                       (rd_data_fall[r_bit] == PAT_FALL[r_bit]);
    assign w_bit_sel = DQ_WIDTH'(1) << r_bit;

    // Window bookkeeping as it will look after this EVAL cycle; the exit decision
    // and the centering pulse count both need the post-update best window.
    assign w_cur_len_upd    = r_pass ? (r_cur_len + 6'd1) : 6'd0;
    assign w_cur_start_upd  = (r_pass && (r_cur_len == 6'd0)) ? r_tap : r_cur_start;
    assign w_best_upd       = r_pass && (w_cur_len_upd > r_best_len);
    assign w_best_len_upd   = w_best_upd ? w_cur_len_upd   : r_best_len;
    assign w_best_start_upd = w_best_upd ? w_cur_start_upd : r_best_start;
    assign w_half           = (w_best_len_upd - 6'd1) >> 1;
    assign w_center         = {1'b0, w_best_start_upd} + w_half;
    assign w_pulses         = TAP_LAST6 - w_center;
    assign w_last_tap       = !(r_tap < TAP_LAST);

    always_ff @(posedge clk90) begin
        if (rst90) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        dlyce       = '0;
        dlyinc      = 1'b0;
        dlyrst      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: if (calib_start) w_state_nxt = ST_RST_TAPS;
            ST_RST_TAPS: begin
                dlyrst      = 1'b1;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: if (!w_match || (r_cnt == SAMPLE_LAST)) w_state_nxt = ST_EVAL;
            ST_EVAL: begin
                if (!w_last_tap)                 w_state_nxt = ST_INC;
                else if (w_best_len_upd == 6'd0) w_state_nxt = ST_ERR;
                else                             w_state_nxt = ST_CENTER;
            end
            ST_INC: begin
                dlyce       = w_bit_sel;
                dlyinc      = 1'b1;
                w_state_nxt = ST_SETTLE;
            end
            // r_cnt holds the decrements still owed; a zero count falls straight through.
            ST_CENTER: begin
                if (r_cnt != 8'd0) dlyce = w_bit_sel;
                else               w_state_nxt = ST_NEXT_BIT;
            end
            ST_NEXT_BIT: w_state_nxt = (r_bit == BIT_LAST) ? ST_DONE : ST_SETTLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk90) begin
        if (rst90) begin
            r_bit        <= '0;
            r_tap        <= '0;
            r_cnt        <= '0;
            r_pass       <= 1'b0;
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
            r_err_bit    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (calib_start) begin
                        r_bit        <= '0;
                        r_tap        <= '0;
                        r_cnt        <= '0;
                        r_pass       <= 1'b0;
                        r_cur_start  <= '0;
                        r_cur_len    <= '0;
                        r_best_start <= '0;
                        r_best_len   <= '0;
                        r_err_bit    <= '0;
                    end
                end
                ST_RST_TAPS: r_cnt <= '0;
                ST_SETTLE:   r_cnt <= (r_cnt == SETTLE_LAST) ? 8'd0 : (r_cnt + 8'd1);
                ST_SAMPLE: begin
                    if (!w_match || (r_cnt == SAMPLE_LAST)) begin
                        r_cnt  <= '0;
                        r_pass <= w_match;
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                    end
                end
                ST_EVAL: begin
                    r_cur_len    <= w_cur_len_upd;
                    r_cur_start  <= w_cur_start_upd;
                    r_best_len   <= w_best_len_upd;
                    r_best_start <= w_best_start_upd;
                    r_cnt        <= {2'b00, w_pulses};
                    if (w_last_tap && (w_best_len_upd == 6'd0)) r_err_bit <= r_bit;
                end
                ST_INC: begin
                    r_tap <= r_tap + 5'd1;
                    r_cnt <= '0;
                end
                ST_CENTER: if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
                ST_NEXT_BIT: begin
                    r_cnt <= '0;
                    if (r_bit != BIT_LAST) begin
                        r_bit        <= r_bit + 3'd1;
                        r_tap        <= '0;
                        r_cur_start  <= '0;
                        r_cur_len    <= '0;
                        r_best_start <= '0;
                        r_best_len   <= '0;
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign calib_busy  = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign calib_done  = (r_state == ST_DONE);
    assign calib_err   = (r_state == ST_ERR);
    assign err_bit     = r_err_bit;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nand_dq_calib_ctrl.sv
// Bench for nand_dq_calib_ctrl: an IDELAY/DQ model answers with per-tap pass maps,
// and each table entry checks the tap every bit is parked at when calibration ends.
module tb_nand_dq_calib_ctrl;

  localparam logic [7:0] PR        = 8'hA5;
  localparam logic [7:0] PF        = 8'h5A;
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SAMPLE = 4'd3;
  localparam logic [31:0] WIN_STD  = 32'h001F_FC00;  // taps 10..20

  typedef struct packed {
    logic [7:0][31:0] win;
    logic             glitch_en;
    logic [2:0]       glitch_bit;
    logic [4:0]       glitch_tap;
    logic             exp_done;
    logic             exp_err;
    logic [2:0]       exp_err_bit;
    logic [7:0][4:0]  exp_tap;
    logic [7:0][5:0]  exp_inc;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk90 = 1'b0;
  logic rst90 = 1'b1;
  logic calib_start = 1'b0;
  always #5 clk90 = ~clk90;

  logic [7:0] rd_data_rise, rd_data_fall, dlyce;
  logic       dlyinc, dlyrst, calib_busy, calib_done, calib_err;
  logic [2:0] err_bit;
  logic [3:0] o_dbg_state;

  nand_dq_calib_ctrl dut (
    .clk90(clk90), .rst90(rst90), .calib_start(calib_start),
    .rd_data_rise(rd_data_rise), .rd_data_fall(rd_data_fall),
    .dlyce(dlyce), .dlyinc(dlyinc), .dlyrst(dlyrst),
    .calib_busy(calib_busy), .calib_done(calib_done), .calib_err(calib_err),
    .err_bit(err_bit), .o_dbg_state(o_dbg_state)
  );

  // ---------------- IDELAY + DQ model ----------------
  logic [7:0][31:0] cur_win = '0;
  logic             g_en = 1'b0;
  logic [2:0]       g_bit = '0;
  logic [4:0]       g_tap = '0;
  logic             mon_clr = 1'b0;
  logic [7:0][4:0]  m_tap = '0;
  int unsigned      inc_cnt[8];
  int unsigned      rst_cnt, viol_cnt, glitch_hits, samp_idx;
  logic             glitch_now;
  logic [7:0]       rr, ff;

  always_comb begin
    glitch_now = g_en && (o_dbg_state == ST_SAMPLE) && (m_tap[g_bit] == g_tap) && (samp_idx == 2);
    rr = PR;
    ff = PF;
    // Failing taps corrupt rise on odd taps and fall on even taps.
    for (int b = 0; b < 8; b++) begin
      if (!cur_win[b][m_tap[b]]) begin
        if (m_tap[b][0]) rr[b] = ~rr[b];
        else             ff[b] = ~ff[b];
      end
    end
    if (glitch_now) rr[g_bit] = ~rr[g_bit];
    rd_data_rise = rr;
    rd_data_fall = ff;
  end

  always @(posedge clk90) begin
    if (mon_clr) begin
      for (int b = 0; b < 8; b++) inc_cnt[b] <= 0;
      rst_cnt <= 0; viol_cnt <= 0; glitch_hits <= 0; samp_idx <= 0;
    end else begin
      if (dlyrst) begin
        m_tap   <= '0;
        rst_cnt <= rst_cnt + 1;
      end else begin
        for (int b = 0; b < 8; b++) begin
          if (dlyce[b]) begin
            if (dlyinc) begin
              m_tap[b]   <= m_tap[b] + 5'd1;
              inc_cnt[b] <= inc_cnt[b] + 1;
            end else begin
              m_tap[b]   <= m_tap[b] - 5'd1;
            end
          end
        end
      end
      viol_cnt <= viol_cnt + (($countones(dlyce) > 1) ? 1 : 0) + ((dlyce == 8'h00 && dlyinc) ? 1 : 0)
                           + ((dlyrst && dlyce != 8'h00) ? 1 : 0);
      if (g_en && (o_dbg_state == ST_SAMPLE) && (m_tap[g_bit] == g_tap)) samp_idx <= samp_idx + 1;
      else                                                                samp_idx <= 0;
      if (glitch_now) glitch_hits <= glitch_hits + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int unsigned   n_vec  = 0;
  int unsigned   n_fail = 0;
  logic [4:0]    exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_monitor();
    mon_clr = 1'b1;
    @(negedge clk90);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    calib_start = 1'b1;
    @(negedge clk90);
    calib_start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " dlyce"},       32'(dlyce), 32'h0);
    check({tag, " dlyinc"},      32'(dlyinc), 32'h0);
    check({tag, " dlyrst"},      32'(dlyrst), 32'h0);
    check({tag, " calib_busy"},  32'(calib_busy), 32'h0);
    check({tag, " calib_done"},  32'(calib_done), 32'h0);
    check({tag, " calib_err"},   32'(calib_err), 32'h0);
    check({tag, " err_bit"},     32'(err_bit), 32'h0);
    check({tag, " state"},       32'(o_dbg_state), 32'(ST_IDLE));
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int extra_start_at);
    bit fin;
    cur_win = v.win;
    g_en    = v.glitch_en;
    g_bit   = v.glitch_bit;
    g_tap   = v.glitch_tap;
    clear_monitor();
    pulse_start();
    check({tag, " busy_after_start"}, 32'(calib_busy), 32'h1);
    check({tag, " dlyrst_pulse"},     32'(dlyrst), 32'h1);
    check({tag, " done_cleared"},     32'(calib_done), 32'h0);
    @(negedge clk90);
    check({tag, " dlyrst_one_cycle"}, 32'(dlyrst), 32'h0);
    fin = 1'b0;
    for (int c = 0; c < 12000 && !fin; c++) begin
      calib_start = (c == extra_start_at);
      @(negedge clk90);
      if (calib_done || calib_err) fin = 1'b1;
    end
    calib_start = 1'b0;
    check({tag, " finished_in_budget"}, 32'(fin), 32'h1);
    check({tag, " calib_done"}, 32'(calib_done), 32'(v.exp_done));
    check({tag, " calib_err"},  32'(calib_err), 32'(v.exp_err));
    check({tag, " err_bit"},    32'(err_bit), 32'(v.exp_err_bit));
    check({tag, " busy_end"},   32'(calib_busy), 32'h0);
    check({tag, " dlyrst_count"}, rst_cnt, 32'd1);
    check({tag, " dlyce_rules"},  viol_cnt, 32'd0);
    for (int b = 0; b < 8; b++) exp_q.push_back(v.exp_tap[b]);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("%s tap[%0d]", tag, b), 32'(m_tap[b]), 32'(exp_q.pop_front()));
      check($sformatf("%s inc[%0d]", tag, b), inc_cnt[b], 32'(v.exp_inc[b]));
    end
    if (v.glitch_en) check({tag, " glitch_hit"}, glitch_hits, 32'd1);
    @(negedge clk90);
    check({tag, " status_held"}, 32'({calib_done, calib_err}), 32'({v.exp_done, v.exp_err}));
  endtask

  function automatic vec_t base_vec();
    vec_t v;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      v.win[b]     = WIN_STD;
      v.exp_tap[b] = 5'd15;
      v.exp_inc[b] = 6'd31;
    end
    v.exp_done = 1'b1;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // window 10..20 everywhere: center 15
    vecs[0] = base_vec();
    // equal-length windows 2..5 and 20..23 on bit 3: earlier one wins, center 3
    vecs[1] = base_vec();
    vecs[1].win[3] = 32'h00F0_003C;  vecs[1].exp_tap[3] = 5'd3;
    // bit 5 never matches: error, later bits untouched
    vecs[2] = base_vec();
    vecs[2].win[5] = 32'h0;          vecs[2].exp_tap[5] = 5'd31;
    vecs[2].exp_tap[6] = 5'd0;       vecs[2].exp_inc[6] = 6'd0;
    vecs[2].exp_tap[7] = 5'd0;       vecs[2].exp_inc[7] = 6'd0;
    vecs[2].exp_done = 1'b0;         vecs[2].exp_err = 1'b1;   vecs[2].exp_err_bit = 3'd5;
    // bit 0 passes everywhere: 32-tap window, center 15
    vecs[3] = base_vec();
    vecs[3].win[0] = 32'hFFFF_FFFF;
    // bit 0 window 8..20 split by a third-sample glitch at tap 12: best 13..20, center 16
    vecs[4] = base_vec();
    vecs[4].win[0] = 32'h001F_FF00;  vecs[4].exp_tap[0] = 5'd16;
    vecs[4].glitch_en = 1'b1;        vecs[4].glitch_bit = 3'd0; vecs[4].glitch_tap = 5'd12;
    // edge windows: tap 0 only, 0..1 vs 30..31 tie, tap 31 only (no decrements), 28..31
    vecs[5] = base_vec();
    vecs[5].win[1] = 32'h0000_0001;  vecs[5].exp_tap[1] = 5'd0;
    vecs[5].win[2] = 32'hC000_0003;  vecs[5].exp_tap[2] = 5'd0;
    vecs[5].win[6] = 32'h8000_0000;  vecs[5].exp_tap[6] = 5'd31;
    vecs[5].win[7] = 32'hF000_0000;  vecs[5].exp_tap[7] = 5'd29;

    clear_monitor();
    repeat (3) @(negedge clk90);
    rst90 = 1'b0;
    check_idle_outputs("reset");
    repeat (4) @(negedge clk90);
    check("idle_without_start busy", 32'(calib_busy), 32'h0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i), -1);

    // Reset while bit 2 is sampling: outputs drop next cycle, taps stay where they were.
    cur_win = vecs[0].win;
    g_en    = 1'b0;
    clear_monitor();
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 8000 && !found; c++) begin
      @(negedge clk90);
      if (inc_cnt[2] >= 3 && o_dbg_state == ST_SAMPLE) found = 1'b1;
    end
    check("midrun reached bit2 sample", 32'(found), 32'h1);
    rst90 = 1'b1;
    @(negedge clk90);
    check_idle_outputs("midrun_reset");
    rst90 = 1'b0;
    @(negedge clk90);
    check("midrun tap[0] kept", 32'(m_tap[0]), 32'd15);
    check("midrun tap[2] kept", 32'(m_tap[2]), 32'd3);
    check("midrun stays idle", 32'(calib_busy), 32'h0);

    // A start pulse in the middle of a sweep must not restart the run.
    run_vec(vecs[0], "busy_start", 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
